i2so_sequencer: RTL and testbench
=================================

# i2so_sequencer

Controller that sits between the filter output and `i2so_serializer`. It generates the I2S bit clock and the `sck_transition` strobe, frames the output into 2×WORD_W-bit stereo frames, and buffers one stereo sample from the filter. At every frame boundary it hands the serializer exactly one sample, or zeros on underrun. It owns all output timing; the serializer only shifts.

## Interface
Parameters:
- `CLK_DIV`, default 4: clk cycles per sck half-period. Legal range 1..255.
- `WORD_W`, default 16: bits per channel.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `en`  in  1  run enable. Level-sensitive.
- `filt_i2so_rts`  in  1  filter has a sample ready to send.
- `filt_i2so_lft`  in  WORD_W  left sample. Valid with rts.
- `filt_i2so_rgt`  in  WORD_W  right sample. Valid with rts.
- `filt_i2so_rtr`  out  1  sequencer ready to receive.
- `i2so_sck`  out  1  I2S bit clock.
- `sck_transition`  out  1  one-clk strobe on every sck falling edge; the serializer shifts on it.
- `ser_load`  out  1  one-clk strobe: the serializer latches `ser_lft`/`ser_rgt` and starts a frame.
- `ser_lft`  out  WORD_W  left word for the serializer.
- `ser_rgt`  out  WORD_W  right word for the serializer.
- `underrun_cnt`  out  8  saturating count of zero-filled frames.
- `busy`  out  1  high in PRIME or RUN.

## Operation
- One-entry buffer: `buf_lft`, `buf_rgt`, `full`.
  - `filt_i2so_rtr = !full || pop`. Forced 0 while `rst` is high.
  - Capture happens on `filt_i2so_rts && filt_i2so_rtr`.
  - A capture in the same cycle as a pop refills the buffer, so `full` stays 1.
- State machine: IDLE, PRIME, RUN.
  - IDLE: divider and sck held at 0, `bit_cnt` = 0. The buffer still accepts one sample. Go to PRIME when `en`=1.
  - PRIME: wait for `full`=1. Divider stays held. Go to RUN on `full`=1. Go to IDLE if `en`=0.
  - RUN: the divider counts 0..CLK_DIV-1. At terminal count sck toggles.
    - Each 1→0 toggle pulses `sck_transition` and advances `bit_cnt` modulo 2×WORD_W.
    - The first `sck_transition` after entering RUN is a frame start. After that, a frame starts on each transition where `bit_cnt` wraps to 0.
  - RUN → IDLE when `en`=0, taking effect immediately:
    - sck goes to 0 on the next clk.
    - no further `sck_transition` or `ser_load`.
    - `bit_cnt` and the divider are cleared; the partial frame is abandoned.
    - the buffer contents are kept.
- Frame start: `ser_load`=1 in the same cycle as that `sck_transition`.
  - If `full`: `ser_lft`/`ser_rgt` = buffer contents (combinational mux) and `pop`=1.
  - Else: `ser_lft`/`ser_rgt` = 0 and `underrun_cnt` increments, saturating at 255.
  - When `ser_load`=0, `ser_lft`/`ser_rgt` show the buffer contents and are don't-care.
- Enable priority: `en` deassertion wins over a coincident frame start. No `ser_load` occurs that cycle.

## Timing
- Reset values: `i2so_sck` 0, `sck_transition` 0, `ser_load` 0, `ser_lft`/`ser_rgt` 0, `filt_i2so_rtr` 0, `underrun_cnt` 0, `busy` 0, state IDLE, `full` 0.
- First release cycle after reset: `filt_i2so_rtr` = 1.
- sck period = 2×CLK_DIV clk. Frame = 2×WORD_W sck periods = 4×CLK_DIV×WORD_W clk.
- Entering RUN: sck rises CLK_DIV clk after the RUN entry edge. The first `sck_transition`/`ser_load` occurs 2×CLK_DIV clk after entry.
- Capture to `full`=1 takes 1 clk. Pop to `full`=0 takes 1 clk, unless there is a same-cycle refill.
- CLK_DIV=1: sck toggles every clk. `sck_transition` occurs every 2 clk.

## Structure
- Package `i2so_pkg`:
  - state enum {IDLE, PRIME, RUN}.
  - `I2SO_WORD_W` = 16.
  - `I2SO_UNDERRUN_W` = 8.
  - function computing `bit_cnt` width = $clog2(2×WORD_W).
- Sub-module `i2so_sck_gen`:
  - inputs: clk, rst, run.
  - outputs: sck, sck_fall strobe.
  - contains the divider. Holds and clears when `run`=0.
- Top-level: buffer, FSM, `bit_cnt`, underrun counter, output mux.

## Test plan
- Reset mid-RUN (`rst` pulsed at an arbitrary clk) → all outputs return to the reset values asynchronously, in the same cycle. After release, state is IDLE and `underrun_cnt` = 0.
- CLK_DIV=2, WORD_W=16. Preload L=0x1234, R=0xABCD, then `en`=1 →
  - first `ser_load` 4 clk after RUN entry, with `ser_lft`=0x1234, `ser_rgt`=0xABCD.
  - `sck_transition` every 4 clk.
  - next `ser_load` 128 clk later.
- Same setup, filter `rts` held low after the first sample →
  - second `ser_load` carries 0/0.
  - `underrun_cnt`=1, then 2 after the following frame.
  - 300 underrun frames → `underrun_cnt` saturates at 255.
- Filter `rts` held high with incrementing samples →
  - each frame's `ser_lft` is exactly the next value: no drops, no duplicates.
  - `filt_i2so_rtr` is high in the pop cycle; capture and pop coincide with `full` staying 1.
- `en` dropped at `bit_cnt`=10 →
  - sck low on the next clk.
  - no `ser_load` afterwards.
  - `en` re-raised → PRIME passes immediately because the buffer is still full; the first frame carries the retained sample.
- `en`=1 with an empty buffer → stays in PRIME, sck idle, `underrun_cnt` unchanged. The first capture → RUN.

Source files
------------

// File: rtl/i2so_pkg.sv
// Shared types and sizing helpers for the I2S output sequencer.
package i2so_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PRIME = 2'd1,
      RUN   = 2'd2
   } i2so_state_e;

   localparam int unsigned I2SO_WORD_W     = 16;
   localparam int unsigned I2SO_UNDERRUN_W = 8;

   // Width of the bit counter that spans one stereo frame of 2*word_w bits.
   function automatic int unsigned i2so_bit_cnt_w(input int unsigned word_w);
      return $clog2(2 * word_w);
   endfunction

endpackage

// File: rtl/i2so_sck_gen.sv
// I2S bit-clock divider: toggles sck every CLK_DIV clk while run is high and
// emits a registered one-clk strobe coincident with each sck falling edge.
module i2so_sck_gen #(
   parameter int unsigned CLK_DIV = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic run,
   output logic sck,
   output logic sck_fall
);

   localparam int unsigned DIV_W = 8;

   logic [DIV_W-1:0] div_q, div_d;
   logic             sck_q, sck_d;
   logic             fall_q, fall_d;
   logic             tc_c;

   assign tc_c = (div_q == DIV_W'(CLK_DIV - 1));

   // Dropping run clears the divider and parks sck low on the next clk.
   always_comb begin
      div_d  = div_q;
      sck_d  = sck_q;
      fall_d = 1'b0;
      if (!run) begin
         div_d = '0;
         sck_d = 1'b0;
      end else if (tc_c) begin
         div_d  = '0;
         sck_d  = !sck_q;
         fall_d = sck_q;
      end else begin
         div_d = div_q + DIV_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_q  <= '0;
         sck_q  <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         div_q  <= div_d;
         sck_q  <= sck_d;
         fall_q <= fall_d;
      end
   end

   assign sck      = sck_q;
   assign sck_fall = fall_q;

endmodule

// File: rtl/i2so_sequencer.sv
// I2S output sequencer: one-sample stereo buffer, run/prime FSM, frame timing
// and zero-fill on underrun, feeding a shift-only serializer.
module i2so_sequencer
   import i2so_pkg::*;
#(
   parameter int unsigned CLK_DIV = 4,
   parameter int unsigned WORD_W  = I2SO_WORD_W
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       en,
   input  logic                       filt_i2so_rts,
   input  logic [WORD_W-1:0]          filt_i2so_lft,
   input  logic [WORD_W-1:0]          filt_i2so_rgt,
   output logic                       filt_i2so_rtr,
   output logic                       i2so_sck,
   output logic                       sck_transition,
   output logic                       ser_load,
   output logic [WORD_W-1:0]          ser_lft,
   output logic [WORD_W-1:0]          ser_rgt,
   output logic [I2SO_UNDERRUN_W-1:0] underrun_cnt,
   output logic                       busy
);

   localparam int unsigned BC_W = i2so_bit_cnt_w(WORD_W);
   localparam int unsigned UR_W = I2SO_UNDERRUN_W;

   i2so_state_e       state_q, state_d;
   logic              full_q, full_d;
   logic [WORD_W-1:0] buf_lft_q, buf_lft_d;
   logic [WORD_W-1:0] buf_rgt_q, buf_rgt_d;
   logic [BC_W-1:0]   bit_cnt_q, bit_cnt_d;
   logic [UR_W-1:0]   under_q, under_d;

   logic run_c, sck_fall, trans_c, load_c, pop_c, cap_c, rtr_c;

   i2so_sck_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_sck_gen (
      .clk      (clk),
      .rst      (rst),
      .run      (run_c),
      .sck      (i2so_sck),
      .sck_fall (sck_fall)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (en) state_d = PRIME;
         PRIME:   if (!en) state_d = IDLE;
                  else if (full_q) state_d = RUN;
         RUN:     if (!en) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Enable gates run combinationally so a drop suppresses any coincident frame start.
   always_comb begin
      run_c = 1'b0;
      busy  = 1'b0;
      case (state_q)
         PRIME:   busy = 1'b1;
         RUN: begin
            busy  = 1'b1;
            run_c = en;
         end
         default: ;
      endcase
   end

   assign trans_c = sck_fall && run_c;
   assign load_c  = trans_c && (bit_cnt_q == '0);
   assign pop_c   = load_c && full_q;
   assign rtr_c   = !rst && (!full_q || pop_c);
   assign cap_c   = filt_i2so_rts && rtr_c;

   assign filt_i2so_rtr  = rtr_c;
   assign sck_transition = trans_c;
   assign ser_load       = load_c;
   assign ser_lft        = (load_c && !full_q) ? '0 : buf_lft_q;
   assign ser_rgt        = (load_c && !full_q) ? '0 : buf_rgt_q;
   assign underrun_cnt   = under_q;

   always_comb begin
      full_d    = full_q;
      buf_lft_d = buf_lft_q;
      buf_rgt_d = buf_rgt_q;
      bit_cnt_d = bit_cnt_q;
      under_d   = under_q;
      if (cap_c) begin
         full_d    = 1'b1;
         buf_lft_d = filt_i2so_lft;
         buf_rgt_d = filt_i2so_rgt;
      end else if (pop_c) begin
         full_d = 1'b0;
      end
      if (!run_c) begin
         bit_cnt_d = '0;
      end else if (trans_c) begin
         if (bit_cnt_q == BC_W'(2 * WORD_W - 1)) bit_cnt_d = '0;
         else                                    bit_cnt_d = bit_cnt_q + BC_W'(1);
      end
      if (load_c && !full_q && (under_q != '1)) begin
         under_d = under_q + UR_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         full_q    <= 1'b0;
         buf_lft_q <= '0;
         buf_rgt_q <= '0;
         bit_cnt_q <= '0;
         under_q   <= '0;
      end else begin
         full_q    <= full_d;
         buf_lft_q <= buf_lft_d;
         buf_rgt_q <= buf_rgt_d;
         bit_cnt_q <= bit_cnt_d;
         under_q   <= under_d;
      end
   end

endmodule

// File: tb/tb_i2so_sequencer.sv
// Randomized bench for i2so_sequencer against an elapsed-time reference model.
module tb_i2so_sequencer;

   localparam int unsigned CD    = 2;
   localparam int unsigned W     = 16;
   localparam int unsigned SCKP  = 2 * CD;
   localparam int unsigned FRAME = 4 * CD * W;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         en  = 1'b0;
   logic         rts = 1'b0;
   logic [W-1:0] lft = '0;
   logic [W-1:0] rgt = '0;
   logic         rtr, sck, trans, load, busy;
   logic [W-1:0] ser_lft, ser_rgt;
   logic [7:0]   underrun_cnt;

   int total = 0;
   int bad   = 0;

   // Reference model: 0 idle, 1 waiting for data, 2 running; m_k = clks since run entry.
   int           m_state;
   int           m_k;
   bit           m_full;
   logic [W-1:0] m_bl, m_br;
   int           m_under;
   bit           m_ld, m_cap;

   always #5 clk = ~clk;

   i2so_sequencer #(
      .CLK_DIV (CD),
      .WORD_W  (W)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .en             (en),
      .filt_i2so_rts  (rts),
      .filt_i2so_lft  (lft),
      .filt_i2so_rgt  (rgt),
      .filt_i2so_rtr  (rtr),
      .i2so_sck       (sck),
      .sck_transition (trans),
      .ser_load       (load),
      .ser_lft        (ser_lft),
      .ser_rgt        (ser_rgt),
      .underrun_cnt   (underrun_cnt),
      .busy           (busy)
   );

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_state = 0;
      m_k     = 0;
      m_full  = 1'b0;
      m_bl    = '0;
      m_br    = '0;
      m_under = 0;
      m_ld    = 1'b0;
      m_cap   = 1'b0;
   endtask

   // Compare current outputs against the model, then advance it over the next edge.
   task automatic eval();
      bit in_run, e_sck, raw, e_tr, e_pop, e_rtr, old_full;
      in_run = (m_state == 2);
      e_sck  = in_run && (((m_k / CD) % 2) == 1);
      raw    = in_run && (m_k > 0) && ((m_k % SCKP) == 0);
      e_tr   = raw && en;
      m_ld   = e_tr && (((m_k - SCKP) % FRAME) == 0);
      e_pop  = m_ld && m_full;
      e_rtr  = !m_full || e_pop;
      chk("sck", sck, e_sck);
      chk("sck_transition", trans, e_tr);
      chk("ser_load", load, m_ld);
      chk("rtr", rtr, e_rtr);
      chk("busy", busy, m_state != 0);
      chk("underrun_cnt", underrun_cnt, 32'(m_under));
      if (m_ld) begin
         chk("ser_lft", ser_lft, m_full ? m_bl : '0);
         chk("ser_rgt", ser_rgt, m_full ? m_br : '0);
      end
      old_full = m_full;
      if (m_ld && !m_full && m_under < 255) m_under++;
      m_cap = rts && e_rtr;
      if (m_cap) begin
         m_full = 1'b1;
         m_bl   = lft;
         m_br   = rgt;
      end else if (e_pop) begin
         m_full = 1'b0;
      end
      case (m_state)
         0: if (en) m_state = 1;
         1: if (!en) m_state = 0;
            else if (old_full) begin
               m_state = 2;
               m_k     = 0;
            end
         default: if (!en) m_state = 0;
                  else m_k++;
      endcase
   endtask

   task automatic step(input bit e, input bit r, input logic [W-1:0] l, input logic [W-1:0] rr);
      @(posedge clk);
      #1;
      en  = e;
      rts = r;
      lft = l;
      rgt = rr;
      @(negedge clk);
      eval();
   endtask

   task automatic chk_reset_vals();
      chk("rst_sck", sck, 0);
      chk("rst_trans", trans, 0);
      chk("rst_load", load, 0);
      chk("rst_lft", ser_lft, 0);
      chk("rst_rgt", ser_rgt, 0);
      chk("rst_rtr", rtr, 0);
      chk("rst_underrun", underrun_cnt, 0);
      chk("rst_busy", busy, 0);
   endtask

   // Asynchronous reset pulse landing mid-cycle.
   task automatic pulse_reset();
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk_reset_vals();
      model_reset();
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      eval();
   endtask

   function automatic logic [W-1:0] rnd();
      return W'($urandom());
   endfunction

   initial begin
      logic [W-1:0] v;
      logic [W-1:0] exp_seq;
      bit           found;

      model_reset();
      repeat (3) @(negedge clk);
      chk_reset_vals();
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      eval();

      // Preload one sample, then run dry so frames zero-fill.
      step(1'b0, 1'b1, 16'h1234, 16'hABCD);
      repeat (3 * FRAME + 10) step(1'b1, 1'b0, rnd(), rnd());
      repeat (300 * FRAME) step(1'b1, 1'b0, rnd(), rnd());
      chk("underrun_sat", underrun_cnt, 32'd255);

      pulse_reset();
      chk("post_rst_underrun", underrun_cnt, 0);

      // Continuous incrementing stream: every frame carries the next value.
      v       = 16'h0100;
      exp_seq = 16'h0100;
      repeat (6 * FRAME) begin
         step(1'b1, 1'b1, v, ~v);
         if (m_ld) begin
            chk("seq", ser_lft, exp_seq);
            exp_seq = exp_seq + W'(1);
         end
         if (m_cap) v = v + W'(1);
      end

      // Drop enable mid-frame with bit_cnt at 10, buffer full.
      found = 1'b0;
      for (int i = 0; i < 2 * FRAME && !found; i++) begin
         step(1'b1, 1'b1, v, ~v);
         if (m_cap) v = v + W'(1);
         if (m_state == 2 && m_k > SCKP && ((m_k - SCKP) % FRAME) == SCKP * 9 + 1) found = 1'b1;
      end
      chk("drop_point_reached", found, 1);
      step(1'b0, 1'b0, rnd(), rnd());
      step(1'b0, 1'b0, rnd(), rnd());
      chk("sck_off_after_drop", sck, 0);
      repeat (20) step(1'b0, 1'b0, rnd(), rnd());
      repeat (2 * FRAME) step(1'b1, 1'b0, rnd(), rnd());

      // Enable with empty buffer: waits in prime until the first capture.
      pulse_reset();
      repeat (50) step(1'b1, 1'b0, rnd(), rnd());
      chk("prime_sck_idle", sck, 0);
      chk("prime_busy", busy, 1);
      step(1'b1, 1'b1, 16'h5A5A, 16'hC3C3);
      repeat (2 * FRAME) step(1'b1, 1'b0, rnd(), rnd());

      // Random traffic with occasional enable drops and resets.
      for (int i = 0; i < 4000; i++) begin
         if (($urandom() % 1500) == 0) pulse_reset();
         else step(($urandom() % 64) != 0, ($urandom() % 4) == 0, rnd(), rnd());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
